// File: rtl/dma_mem_arbiter_pkg.sv
// Shared encodings and helpers for the CPU/DMA memory-port arbiter.
package dma_mem_arbiter_pkg;

  // One-hot channel states.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_REQ  = 3'b010,
    S_DATA = 3'b100
  } state_e;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

  // On a tie pick the master that did not win last time, otherwise the sole requester.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    if (req == 2'b11) begin
      return ~last_grant;
    end
    return req[1] ? MASTER_DMA : MASTER_CPU;
  endfunction

endpackage

// File: rtl/dma_mem_arbiter_rr_arb2_lock.sv
// Two-requester round-robin arbiter with a registered grant that is frozen while locked.
module rr_arb2_lock
  import dma_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic       grant
);

  logic grant_q, grant_d;
  logic last_q, last_d;

  // Re-arbitrate only while the channel is unlocked and someone is asking.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    if (!lock && (req != 2'b00)) begin
      grant_d = rr_pick(req, last_q);
      last_d  = grant_d;
    end
  end

  // Grant and round-robin history registers; history starts at DMA so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= MASTER_CPU;
      last_q  <= MASTER_DMA;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/dma_mem_arbiter.sv
// Shares one memory port between the CPU data port (m0) and the DMA engine (m1).
// Read and write channels arbitrate independently and stay locked for a whole burst.
module dma_mem_arbiter
  import dma_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_rd_req_addr,
  input  logic [LEN_WIDTH-1:0]  m0_rd_req_len,
  input  logic                  m0_rd_req_valid,
  output logic                  m0_rd_req_ready,
  output logic [DATA_WIDTH-1:0] m0_rd_rdata,
  output logic                  m0_rd_last,
  output logic                  m0_rd_valid,
  input  logic                  m0_rd_ready,
  input  logic [ADDR_WIDTH-1:0] m0_wr_req_addr,
  input  logic [LEN_WIDTH-1:0]  m0_wr_req_len,
  input  logic                  m0_wr_req_valid,
  output logic                  m0_wr_req_ready,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  input  logic                  m0_wr_last,
  input  logic                  m0_wr_valid,
  output logic                  m0_wr_ready,
  input  logic [ADDR_WIDTH-1:0] m1_rd_req_addr,
  input  logic [LEN_WIDTH-1:0]  m1_rd_req_len,
  input  logic                  m1_rd_req_valid,
  output logic                  m1_rd_req_ready,
  output logic [DATA_WIDTH-1:0] m1_rd_rdata,
  output logic                  m1_rd_last,
  output logic                  m1_rd_valid,
  input  logic                  m1_rd_ready,
  input  logic [ADDR_WIDTH-1:0] m1_wr_req_addr,
  input  logic [LEN_WIDTH-1:0]  m1_wr_req_len,
  input  logic                  m1_wr_req_valid,
  output logic                  m1_wr_req_ready,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  input  logic                  m1_wr_last,
  input  logic                  m1_wr_valid,
  output logic                  m1_wr_ready,
  output logic [ADDR_WIDTH-1:0] s_rd_req_addr,
  output logic [LEN_WIDTH-1:0]  s_rd_req_len,
  output logic                  s_rd_req_valid,
  input  logic                  s_rd_req_ready,
  input  logic [DATA_WIDTH-1:0] s_rd_rdata,
  input  logic                  s_rd_last,
  input  logic                  s_rd_valid,
  output logic                  s_rd_ready,
  output logic [ADDR_WIDTH-1:0] s_wr_req_addr,
  output logic [LEN_WIDTH-1:0]  s_wr_req_len,
  output logic                  s_wr_req_valid,
  input  logic                  s_wr_req_ready,
  output logic [DATA_WIDTH-1:0] s_wr_data,
  output logic                  s_wr_last,
  output logic                  s_wr_valid,
  input  logic                  s_wr_ready
);

  // Master-indexed views so the grant can select directly.
  logic [1:0]                 rd_req_valid, rd_ready_m, wr_req_valid, wr_valid_m, wr_last_m;
  logic [1:0][ADDR_WIDTH-1:0] rd_req_addr, wr_req_addr;
  logic [1:0][LEN_WIDTH-1:0]  rd_req_len, wr_req_len;
  logic [1:0][DATA_WIDTH-1:0] wr_data_m;

  assign rd_req_valid = {m1_rd_req_valid, m0_rd_req_valid};
  assign rd_req_addr  = {m1_rd_req_addr, m0_rd_req_addr};
  assign rd_req_len   = {m1_rd_req_len, m0_rd_req_len};
  assign rd_ready_m   = {m1_rd_ready, m0_rd_ready};
  assign wr_req_valid = {m1_wr_req_valid, m0_wr_req_valid};
  assign wr_req_addr  = {m1_wr_req_addr, m0_wr_req_addr};
  assign wr_req_len   = {m1_wr_req_len, m0_wr_req_len};
  assign wr_data_m    = {m1_wr_data, m0_wr_data};
  assign wr_last_m    = {m1_wr_last, m0_wr_last};
  assign wr_valid_m   = {m1_wr_valid, m0_wr_valid};

  state_e               rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic                 rd_grant, wr_grant;
  logic [LEN_WIDTH-1:0] rd_cnt_q, rd_len_q, wr_cnt_q, wr_len_q;
  logic                 rd_err_q, wr_err_q;
  logic                 rd_beat, wr_beat;

  // Arbitration happens only in IDLE, so the grant is frozen from REQ to burst end.
  rr_arb2_lock u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (rd_req_valid),
    .lock  (rd_state_q != S_IDLE),
    .grant (rd_grant)
  );

  rr_arb2_lock u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wr_req_valid),
    .lock  (wr_state_q != S_IDLE),
    .grant (wr_grant)
  );

  assign rd_beat = (rd_state_q == S_DATA) && s_rd_valid && s_rd_ready;
  assign wr_beat = (wr_state_q == S_DATA) && s_wr_valid && s_wr_ready;

  // Read channel routing, decoded from registered state and grant.
  always_comb begin
    s_rd_req_addr   = '0;
    s_rd_req_len    = '0;
    s_rd_req_valid  = 1'b0;
    s_rd_ready      = 1'b0;
    m0_rd_req_ready = 1'b0;
    m1_rd_req_ready = 1'b0;
    m0_rd_rdata     = '0;
    m0_rd_last      = 1'b0;
    m0_rd_valid     = 1'b0;
    m1_rd_rdata     = '0;
    m1_rd_last      = 1'b0;
    m1_rd_valid     = 1'b0;
    if (rd_state_q == S_REQ) begin
      s_rd_req_addr   = rd_req_addr[rd_grant];
      s_rd_req_len    = rd_req_len[rd_grant];
      s_rd_req_valid  = rd_req_valid[rd_grant];
      m0_rd_req_ready = (rd_grant == MASTER_CPU) && s_rd_req_ready;
      m1_rd_req_ready = (rd_grant == MASTER_DMA) && s_rd_req_ready;
    end
    if (rd_state_q == S_DATA) begin
      s_rd_ready = rd_ready_m[rd_grant];
      if (rd_grant == MASTER_CPU) begin
        m0_rd_rdata = s_rd_rdata;
        m0_rd_last  = s_rd_last;
        m0_rd_valid = s_rd_valid;
      end else begin
        m1_rd_rdata = s_rd_rdata;
        m1_rd_last  = s_rd_last;
        m1_rd_valid = s_rd_valid;
      end
    end
  end

  // Write channel routing, decoded from registered state and grant.
  always_comb begin
    s_wr_req_addr   = '0;
    s_wr_req_len    = '0;
    s_wr_req_valid  = 1'b0;
    s_wr_data       = '0;
    s_wr_last       = 1'b0;
    s_wr_valid      = 1'b0;
    m0_wr_req_ready = 1'b0;
    m1_wr_req_ready = 1'b0;
    m0_wr_ready     = 1'b0;
    m1_wr_ready     = 1'b0;
    if (wr_state_q == S_REQ) begin
      s_wr_req_addr   = wr_req_addr[wr_grant];
      s_wr_req_len    = wr_req_len[wr_grant];
      s_wr_req_valid  = wr_req_valid[wr_grant];
      m0_wr_req_ready = (wr_grant == MASTER_CPU) && s_wr_req_ready;
      m1_wr_req_ready = (wr_grant == MASTER_DMA) && s_wr_req_ready;
    end
    if (wr_state_q == S_DATA) begin
      s_wr_data   = wr_data_m[wr_grant];
      s_wr_last   = wr_last_m[wr_grant];
      s_wr_valid  = wr_valid_m[wr_grant];
      m0_wr_ready = (wr_grant == MASTER_CPU) && s_wr_ready;
      m1_wr_ready = (wr_grant == MASTER_DMA) && s_wr_ready;
    end
  end

  // Channel FSMs; a burst ends only on an accepted last beat, regardless of the beat count.
  always_comb begin
    rd_state_d = rd_state_q;
    wr_state_d = wr_state_q;
    unique case (rd_state_q)
      S_IDLE:  if (rd_req_valid != 2'b00) rd_state_d = S_REQ;
      S_REQ:   if (s_rd_req_valid && s_rd_req_ready) rd_state_d = S_DATA;
      S_DATA:  if (rd_beat && s_rd_last) rd_state_d = S_IDLE;
      default: rd_state_d = S_IDLE;
    endcase
    unique case (wr_state_q)
      S_IDLE:  if (wr_req_valid != 2'b00) wr_state_d = S_REQ;
      S_REQ:   if (s_wr_req_valid && s_wr_req_ready) wr_state_d = S_DATA;
      S_DATA:  if (wr_beat && s_wr_last) wr_state_d = S_IDLE;
      default: wr_state_d = S_IDLE;
    endcase
  end

  // State, beat counters and sticky length-mismatch flags (debug visibility only).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= S_IDLE;
      wr_state_q <= S_IDLE;
      rd_cnt_q   <= '0;
      rd_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_len_q   <= '0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      if (rd_state_q == S_REQ) begin
        rd_cnt_q <= '0;
        rd_len_q <= s_rd_req_len;
      end else if (rd_beat) begin
        rd_cnt_q <= rd_cnt_q + LEN_WIDTH'(1);
        if (s_rd_last != (rd_cnt_q == rd_len_q)) rd_err_q <= 1'b1;
      end
      if (wr_state_q == S_REQ) begin
        wr_cnt_q <= '0;
        wr_len_q <= s_wr_req_len;
      end else if (wr_beat) begin
        wr_cnt_q <= wr_cnt_q + LEN_WIDTH'(1);
        if (s_wr_last != (wr_cnt_q == wr_len_q)) wr_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed bench for dma_mem_arbiter: master/memory models plus per-master scoreboards.
module tb_dma_mem_arbiter;
  import dma_mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] m0_rd_req_addr, m1_rd_req_addr, m0_wr_req_addr, m1_wr_req_addr;
  logic [LW-1:0] m0_rd_req_len, m1_rd_req_len, m0_wr_req_len, m1_wr_req_len;
  logic m0_rd_req_valid, m0_rd_req_ready, m0_rd_last, m0_rd_valid, m0_rd_ready;
  logic m1_rd_req_valid, m1_rd_req_ready, m1_rd_last, m1_rd_valid, m1_rd_ready;
  logic m0_wr_req_valid, m0_wr_req_ready, m0_wr_last, m0_wr_valid, m0_wr_ready;
  logic m1_wr_req_valid, m1_wr_req_ready, m1_wr_last, m1_wr_valid, m1_wr_ready;
  logic [DW-1:0] m0_rd_rdata, m1_rd_rdata, m0_wr_data, m1_wr_data;
  logic [AW-1:0] s_rd_req_addr, s_wr_req_addr;
  logic [LW-1:0] s_rd_req_len, s_wr_req_len;
  logic s_rd_req_valid, s_rd_req_ready, s_rd_last, s_rd_valid, s_rd_ready;
  logic s_wr_req_valid, s_wr_req_ready, s_wr_last, s_wr_valid, s_wr_ready;
  logic [DW-1:0] s_rd_rdata, s_wr_data;

  dma_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_req_addr(m0_rd_req_addr), .m0_rd_req_len(m0_rd_req_len),
    .m0_rd_req_valid(m0_rd_req_valid), .m0_rd_req_ready(m0_rd_req_ready),
    .m0_rd_rdata(m0_rd_rdata), .m0_rd_last(m0_rd_last), .m0_rd_valid(m0_rd_valid),
    .m0_rd_ready(m0_rd_ready),
    .m0_wr_req_addr(m0_wr_req_addr), .m0_wr_req_len(m0_wr_req_len),
    .m0_wr_req_valid(m0_wr_req_valid), .m0_wr_req_ready(m0_wr_req_ready),
    .m0_wr_data(m0_wr_data), .m0_wr_last(m0_wr_last), .m0_wr_valid(m0_wr_valid),
    .m0_wr_ready(m0_wr_ready),
    .m1_rd_req_addr(m1_rd_req_addr), .m1_rd_req_len(m1_rd_req_len),
    .m1_rd_req_valid(m1_rd_req_valid), .m1_rd_req_ready(m1_rd_req_ready),
    .m1_rd_rdata(m1_rd_rdata), .m1_rd_last(m1_rd_last), .m1_rd_valid(m1_rd_valid),
    .m1_rd_ready(m1_rd_ready),
    .m1_wr_req_addr(m1_wr_req_addr), .m1_wr_req_len(m1_wr_req_len),
    .m1_wr_req_valid(m1_wr_req_valid), .m1_wr_req_ready(m1_wr_req_ready),
    .m1_wr_data(m1_wr_data), .m1_wr_last(m1_wr_last), .m1_wr_valid(m1_wr_valid),
    .m1_wr_ready(m1_wr_ready),
    .s_rd_req_addr(s_rd_req_addr), .s_rd_req_len(s_rd_req_len),
    .s_rd_req_valid(s_rd_req_valid), .s_rd_req_ready(s_rd_req_ready),
    .s_rd_rdata(s_rd_rdata), .s_rd_last(s_rd_last), .s_rd_valid(s_rd_valid),
    .s_rd_ready(s_rd_ready),
    .s_wr_req_addr(s_wr_req_addr), .s_wr_req_len(s_wr_req_len),
    .s_wr_req_valid(s_wr_req_valid), .s_wr_req_ready(s_wr_req_ready),
    .s_wr_data(s_wr_data), .s_wr_last(s_wr_last), .s_wr_valid(s_wr_valid),
    .s_wr_ready(s_wr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model state: pending master commands, memory read responder, write data generators.
  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  logic [1:0]    rd_pend = '0;
  logic [1:0]    wr_pend = '0;
  logic [AW-1:0] rd_addr_c[2] = '{32'h0, 32'h0};
  logic [AW-1:0] wr_addr_c[2] = '{32'h0, 32'h0};
  logic [LW-1:0] rd_len_c[2] = '{5'd0, 5'd0};
  logic [LW-1:0] wr_len_c[2] = '{5'd0, 5'd0};
  bit            m1_wr_cont = 1'b0;
  bit            mem_wr_rdy_en = 1'b1;
  int            wr_left[2] = '{0, 0};
  int            wr_idx[2] = '{0, 0};
  int            wr_bnum[2] = '{0, 0};
  int            wr_bcnt[2] = '{0, 0};
  int            rd_beats[2] = '{0, 0};
  int            wr_beats = 0;
  int            mem_rd_left = 0;
  int            mem_rd_idx = 0;
  logic [AW-1:0] mem_rd_addr = '0;
  beat_t         rd_q0[$], rd_q1[$], wr_q[$];
  int            rd_log_m[$], rd_log_cyc[$], rd_last_cyc[$], wr_log_m[$];

  function automatic logic [DW-1:0] wr_word(input int m, input int b, input int k);
    return DW'(32'h1000_0000 * (m + 1) + b * 256 + k);
  endfunction

  function automatic logic [11:0] out_vr();
    return {m0_rd_req_ready, m0_rd_valid, m0_wr_req_ready, m0_wr_ready,
            m1_rd_req_ready, m1_rd_valid, m1_wr_req_ready, m1_wr_ready,
            s_rd_req_valid, s_rd_ready, s_wr_req_valid, s_wr_valid};
  endfunction

  function automatic bit quiet();
    return (rd_pend == 2'b00) && (wr_pend == 2'b00) && (rd_q0.size() == 0) &&
           (rd_q1.size() == 0) && (wr_q.size() == 0) && (mem_rd_left == 0) &&
           (wr_left[0] == 0) && (wr_left[1] == 0);
  endfunction

  task automatic push_rd(input int m);
    beat_t b;
    for (int k = 0; k <= int'(rd_len_c[m]); k++) begin
      b.data = rd_addr_c[m] + DW'(k);
      b.last = (k == int'(rd_len_c[m]));
      if (m == 0) rd_q0.push_back(b);
      else rd_q1.push_back(b);
    end
  endtask

  task automatic push_wr(input int m);
    beat_t b;
    wr_bnum[m] = wr_bcnt[m];
    wr_bcnt[m]++;
    wr_left[m] = int'(wr_len_c[m]) + 1;
    wr_idx[m] = 0;
    for (int k = 0; k <= int'(wr_len_c[m]); k++) begin
      b.data = wr_word(m, wr_bnum[m], k);
      b.last = (k == int'(wr_len_c[m]));
      wr_q.push_back(b);
    end
  endtask

  // Bus models: drive inputs at negedge, evaluate the upcoming edge's handshakes 1 ns later.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      m0_rd_req_valid = rd_pend[0]; m0_rd_req_addr = rd_addr_c[0]; m0_rd_req_len = rd_len_c[0];
      m1_rd_req_valid = rd_pend[1]; m1_rd_req_addr = rd_addr_c[1]; m1_rd_req_len = rd_len_c[1];
      m0_wr_req_valid = wr_pend[0]; m0_wr_req_addr = wr_addr_c[0]; m0_wr_req_len = wr_len_c[0];
      m1_wr_req_valid = wr_pend[1]; m1_wr_req_addr = wr_addr_c[1]; m1_wr_req_len = wr_len_c[1];
      m0_wr_valid = (wr_left[0] > 0); m0_wr_last = (wr_left[0] == 1);
      m0_wr_data  = (wr_left[0] > 0) ? wr_word(0, wr_bnum[0], wr_idx[0]) : '0;
      m1_wr_valid = (wr_left[1] > 0); m1_wr_last = (wr_left[1] == 1);
      m1_wr_data  = (wr_left[1] > 0) ? wr_word(1, wr_bnum[1], wr_idx[1]) : '0;
      s_rd_valid = (mem_rd_left > 0); s_rd_last = (mem_rd_left == 1);
      s_rd_rdata = mem_rd_addr + DW'(mem_rd_idx);
      s_rd_req_ready = (mem_rd_left == 0);
      s_wr_req_ready = mem_wr_rdy_en;
      s_wr_ready = 1'b1;
      m0_rd_ready = 1'b1;
      m1_rd_ready = 1'b1;
      #1;
      if (m0_rd_req_valid && m0_rd_req_ready) begin
        rd_pend[0] = 1'b0; push_rd(0); rd_log_m.push_back(0); rd_log_cyc.push_back(cyc);
      end
      if (m1_rd_req_valid && m1_rd_req_ready) begin
        rd_pend[1] = 1'b0; push_rd(1); rd_log_m.push_back(1); rd_log_cyc.push_back(cyc);
      end
      if (s_rd_req_valid && s_rd_req_ready) begin
        check("rd_req_hs_routed", m0_rd_req_ready ^ m1_rd_req_ready, 1);
        check("s_rd_req_addr", s_rd_req_addr, m1_rd_req_ready ? rd_addr_c[1] : rd_addr_c[0]);
        mem_rd_left = int'(s_rd_req_len) + 1;
        mem_rd_addr = s_rd_req_addr;
        mem_rd_idx = 0;
      end
      if (s_rd_valid && s_rd_ready) begin
        mem_rd_idx++;
        mem_rd_left--;
        if (s_rd_last) rd_last_cyc.push_back(cyc);
      end
      if (m0_rd_valid && m0_rd_ready) begin
        rd_beats[0]++;
        check("m0_rd_expected", rd_q0.size() > 0, 1);
        if (rd_q0.size() > 0) begin
          e = rd_q0.pop_front();
          check("m0_rd_data", m0_rd_rdata, e.data);
          check("m0_rd_last", m0_rd_last, e.last);
        end
      end
      if (m1_rd_valid && m1_rd_ready) begin
        rd_beats[1]++;
        check("m1_rd_expected", rd_q1.size() > 0, 1);
        if (rd_q1.size() > 0) begin
          e = rd_q1.pop_front();
          check("m1_rd_data", m1_rd_rdata, e.data);
          check("m1_rd_last", m1_rd_last, e.last);
        end
      end
      if (m0_wr_req_valid && m0_wr_req_ready) begin
        wr_pend[0] = 1'b0; push_wr(0); wr_log_m.push_back(0);
      end
      if (m1_wr_req_valid && m1_wr_req_ready) begin
        wr_pend[1] = m1_wr_cont; push_wr(1); wr_log_m.push_back(1);
      end
      if (m0_wr_valid && m0_wr_ready) begin wr_idx[0]++; wr_left[0]--; end
      if (m1_wr_valid && m1_wr_ready) begin wr_idx[1]++; wr_left[1]--; end
      if (s_wr_valid && s_wr_ready) begin
        wr_beats++;
        check("s_wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("s_wr_data", s_wr_data, e.data);
          check("s_wr_last", s_wr_last, e.last);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (quiet()) break;
      step();
    end
    check({tag, "_complete"}, quiet(), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int b0, b1, wb, base, lbase, n;

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check("rst_valid_ready", out_vr(), 12'h000);
    check("rst_data_zero", |{s_rd_req_addr, s_rd_req_len, s_wr_req_addr, s_wr_req_len,
                             s_wr_data, m0_rd_rdata, m1_rd_rdata}, 0);
    check("rst_rd_state", dut.rd_state_q === S_IDLE, 1);
    check("rst_wr_state", dut.wr_state_q === S_IDLE, 1);
    rst = 1'b0;
    step();
    check("idle_valid_ready", out_vr(), 12'h000);

    // Lone DMA read: request seen on memory side one cycle after arbitration.
    b0 = rd_beats[0]; b1 = rd_beats[1];
    rd_addr_c[1] = 32'h100; rd_len_c[1] = 5'd7; rd_pend[1] = 1'b1;
    step();
    check("t1_arb_cycle_valid", s_rd_req_valid, 0);
    step();
    check("t1_s_req_valid", s_rd_req_valid, 1);
    check("t1_s_req_addr", s_rd_req_addr, 32'h100);
    check("t1_s_req_len", s_rd_req_len, 5'd7);
    check("t1_m1_req_ready", m1_rd_req_ready, 1);
    check("t1_m0_req_ready", m0_rd_req_ready, 0);
    wait_quiet("t1", 200);
    check("t1_m1_beats", rd_beats[1] - b1, 8);
    check("t1_m0_beats", rd_beats[0] - b0, 0);

    // Simultaneous reads after reset: CPU first, DMA one idle cycle after CPU's last beat.
    rst = 1'b1; step(); rst = 1'b0; step();
    base = rd_log_m.size(); lbase = rd_last_cyc.size();
    rd_addr_c[0] = 32'h200; rd_len_c[0] = 5'd3;
    rd_addr_c[1] = 32'h300; rd_len_c[1] = 5'd2;
    rd_pend = 2'b11;
    wait_quiet("t2", 200);
    check("t2_grant_count", rd_log_m.size() - base, 2);
    if (rd_log_m.size() >= base + 2 && rd_last_cyc.size() > lbase) begin
      check("t2_first_grant", rd_log_m[base], 0);
      check("t2_second_grant", rd_log_m[base+1], 1);
      check("t2_second_req_cycle", rd_log_cyc[base+1], rd_last_cyc[lbase] + 2);
    end

    // DMA keeps requesting writes; the single CPU request must win the next burst.
    base = wr_log_m.size(); wb = wr_beats;
    wr_addr_c[1] = 32'h1000; wr_len_c[1] = 5'd3; m1_wr_cont = 1'b1; wr_pend[1] = 1'b1;
    n = 0;
    while (wr_log_m.size() <= base && n < 50) begin step(); n++; end
    wr_addr_c[0] = 32'h2000; wr_len_c[0] = 5'd3; wr_pend[0] = 1'b1;
    n = 0;
    while (wr_log_m.size() < base + 3 && n < 100) begin step(); n++; end
    m1_wr_cont = 1'b0; wr_pend[1] = 1'b0;
    wait_quiet("t3", 200);
    check("t3_grant_count", wr_log_m.size() - base, 3);
    if (wr_log_m.size() >= base + 3) begin
      check("t3_grant0", wr_log_m[base], 1);
      check("t3_grant1", wr_log_m[base+1], 0);
      check("t3_grant2", wr_log_m[base+2], 1);
    end
    check("t3_wr_beats", wr_beats - wb, 12);

    // Concurrent CPU single-beat read and DMA 8-beat write.
    b0 = rd_beats[0]; b1 = rd_beats[1]; wb = wr_beats;
    rd_addr_c[0] = 32'h400; rd_len_c[0] = 5'd0; rd_pend[0] = 1'b1;
    wr_addr_c[1] = 32'h3000; wr_len_c[1] = 5'd7; wr_pend[1] = 1'b1;
    wait_quiet("t4", 200);
    check("t4_m0_beats", rd_beats[0] - b0, 1);
    check("t4_m1_beats", rd_beats[1] - b1, 0);
    check("t4_wr_beats", wr_beats - wb, 8);

    // Memory stalls the write request: grant stays locked on DMA.
    base = wr_log_m.size();
    mem_wr_rdy_en = 1'b0;
    wr_addr_c[1] = 32'h5000; wr_len_c[1] = 5'd1; wr_pend[1] = 1'b1;
    step();
    wr_addr_c[0] = 32'h6000; wr_len_c[0] = 5'd1; wr_pend[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_s_req_valid", s_wr_req_valid, 1);
      check("t5_s_req_addr", s_wr_req_addr, 32'h5000);
      check("t5_m1_req_ready", m1_wr_req_ready, 0);
      check("t5_m0_req_ready", m0_wr_req_ready, 0);
    end
    mem_wr_rdy_en = 1'b1;
    wait_quiet("t5", 200);
    check("t5_grant_count", wr_log_m.size() - base, 2);
    if (wr_log_m.size() >= base + 2) begin
      check("t5_grant0", wr_log_m[base], 1);
      check("t5_grant1", wr_log_m[base+1], 0);
    end

    // Reset in the middle of an 8-beat read.
    b0 = rd_beats[0];
    rd_addr_c[0] = 32'h700; rd_len_c[0] = 5'd7; rd_pend[0] = 1'b1;
    n = 0;
    while (rd_beats[0] - b0 < 3 && n < 50) begin step(); n++; end
    check("t6_reached_beat3", rd_beats[0] - b0, 3);
    rst = 1'b1;
    step();
    check("t6_rst_valid_ready", out_vr(), 12'h000);
    check("t6_rd_state", dut.rd_state_q === S_IDLE, 1);
    check("t6_wr_state", dut.wr_state_q === S_IDLE, 1);
    mem_rd_left = 0; rd_q0.delete(); rd_pend = 2'b00;
    step();
    rst = 1'b0;
    step();
    check("t6_post_rst_idle", out_vr(), 12'h000);
    b1 = rd_beats[1];
    rd_addr_c[1] = 32'h800; rd_len_c[1] = 5'd1; rd_pend[1] = 1'b1;
    wait_quiet("t6_recover", 200);
    check("t6_recover_beats", rd_beats[1] - b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
